// File: rtl/rebuster_pkg.sv
// Shared definitions for the Zorro bus-request front end: slot FSM encoding,
// default sizing and the timeout counter width helper.
package rebuster_pkg;

    typedef enum logic [1:0] {
        S_HIGH = 2'd0,
        S_LOW1 = 2'd1,
        S_LOWN = 2'd2
    } slot_state_t;

    localparam int NUM_SLOTS_DEFAULT      = 5;
    localparam int TIMEOUT_CYCLES_DEFAULT = 4096;

    // Counter must be able to hold the terminal value itself.
    function automatic int timeout_cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/ebr_slot_fsm.sv
// Per-slot EBR_n classifier: single low sample toggles Z3 registration, a held
// low is a Z2 request. EBR_TIMEOUT_EN adds a held-request timeout and fault flag.
module ebr_slot_fsm
    import rebuster_pkg::*;
`ifdef EBR_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
`endif
(
    input  logic clk100,
    input  logic reset_n_in,
    input  logic sample,
    input  logic ebr_bit,
    output logic toggle,
    output logic z2,
    output logic fault
);

    slot_state_t state_reg;
    slot_state_t state_next;

    always_ff @(posedge clk100) begin
        if (!reset_n_in) begin
            state_reg <= S_HIGH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (sample) begin
            case (state_reg)
                S_HIGH:  if (!ebr_bit) state_next = S_LOW1;
                S_LOW1:  state_next = ebr_bit ? S_HIGH : S_LOWN;
                S_LOWN:  if (ebr_bit) state_next = S_HIGH;
                default: state_next = S_HIGH;
            endcase
        end
    end

`ifdef EBR_TIMEOUT_EN
    localparam int                CNT_W   = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_reg;

    // Any strobe outside S_LOWN zeroes the count, so it starts at 0 on entry.
    always_ff @(posedge clk100) begin
        if (!reset_n_in) begin
            cnt_reg <= '0;
        end else if (sample) begin
            if (state_reg != S_LOWN) begin
                cnt_reg <= '0;
            end else if (!ebr_bit && (cnt_reg != CNT_MAX)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        toggle = sample && (state_reg == S_LOW1) && ebr_bit;
`ifdef EBR_TIMEOUT_EN
        fault  = (state_reg == S_LOWN) && (cnt_reg == CNT_MAX);
`else
        fault  = 1'b0;
`endif
        z2     = (state_reg == S_LOWN) && !fault;
    end

endmodule

// File: rtl/ebr_request_decoder.sv
// Zorro EBR_n front end: synchronizes C7M and slot EBR_n, strobes on C7M falls
// and classifies each slot into Z3 toggles / Z2 requests. Option: EBR_TIMEOUT_EN.
module ebr_request_decoder
    import rebuster_pkg::*;
#(
    parameter int NUM_SLOTS      = NUM_SLOTS_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                 clk100,
    input  logic                 reset_n_in,
    input  logic                 c7m_in,
    input  logic [NUM_SLOTS-1:0] ebr_n_in,
    output logic                 c7m_falling,
    output logic [NUM_SLOTS-1:0] z3_requests,
    output logic [NUM_SLOTS-1:0] z2_requests,
    output logic [NUM_SLOTS-1:0] z3_pulse,
    output logic [NUM_SLOTS-1:0] slot_fault
);

    if (NUM_SLOTS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("ebr_request_decoder: NUM_SLOTS and TIMEOUT_CYCLES must be positive");
    end

    logic [2:0]           c7m_sync_reg;
    logic                 c7m_falling_reg;
    logic [NUM_SLOTS-1:0] ebr_meta_reg;
    logic [NUM_SLOTS-1:0] ebr_sync_reg;
    logic [NUM_SLOTS-1:0] z3_requests_reg;
    logic [NUM_SLOTS-1:0] z3_pulse_reg;
    logic [NUM_SLOTS-1:0] toggle_next;
    logic [NUM_SLOTS-1:0] slot_z2;
    logic [NUM_SLOTS-1:0] slot_fault_vec;

    // EBR_n idles high, so its synchronizer resets high to avoid a false low sample.
    always_ff @(posedge clk100) begin
        if (!reset_n_in) begin
            c7m_sync_reg    <= '0;
            c7m_falling_reg <= 1'b0;
            ebr_meta_reg    <= '1;
            ebr_sync_reg    <= '1;
        end else begin
            c7m_sync_reg    <= {c7m_sync_reg[1:0], c7m_in};
            c7m_falling_reg <= (c7m_sync_reg[2:1] == 2'b10);
            ebr_meta_reg    <= ebr_n_in;
            ebr_sync_reg    <= ebr_meta_reg;
        end
    end

    always_ff @(posedge clk100) begin
        if (!reset_n_in) begin
            z3_requests_reg <= '0;
            z3_pulse_reg    <= '0;
        end else begin
            z3_requests_reg <= z3_requests_reg ^ toggle_next;
            z3_pulse_reg    <= toggle_next;
        end
    end

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        ebr_slot_fsm
`ifdef EBR_TIMEOUT_EN
        #(
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        )
`endif
        u_slot (
            .clk100     (clk100),
            .reset_n_in (reset_n_in),
            .sample     (c7m_falling_reg),
            .ebr_bit    (ebr_sync_reg[gi]),
            .toggle     (toggle_next[gi]),
            .z2         (slot_z2[gi]),
            .fault      (slot_fault_vec[gi])
        );
    end

    assign c7m_falling = c7m_falling_reg;
    assign z3_requests = z3_requests_reg;
    assign z2_requests = slot_z2;
    assign z3_pulse    = z3_pulse_reg;
    assign slot_fault  = slot_fault_vec;

endmodule

// File: tb/tb_ebr_request_decoder.sv
// Directed bench for ebr_request_decoder: each C7M period is one transaction,
// expected outputs come from a low-run-length model via a scoreboard queue.
module tb_ebr_request_decoder;

    localparam int N  = 5;
    localparam int TO = 8;
`ifdef EBR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk100 = 1'b0;
    logic         reset_n_in;
    logic         c7m_in;
    logic [N-1:0] ebr_n_in;
    logic         c7m_falling;
    logic [N-1:0] z3_requests;
    logic [N-1:0] z2_requests;
    logic [N-1:0] z3_pulse;
    logic [N-1:0] slot_fault;

    ebr_request_decoder #(
        .NUM_SLOTS      (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk100      (clk100),
        .reset_n_in  (reset_n_in),
        .c7m_in      (c7m_in),
        .ebr_n_in    (ebr_n_in),
        .c7m_falling (c7m_falling),
        .z3_requests (z3_requests),
        .z2_requests (z2_requests),
        .z3_pulse    (z3_pulse),
        .slot_fault  (slot_fault)
    );

    always #5 clk100 = ~clk100;

    typedef struct {
        logic [N-1:0] z3;
        logic [N-1:0] z2;
        logic [N-1:0] fault;
        logic [N-1:0] pulse;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Running totals sampled on the falling clock edge, diffed per transaction.
    int fall_cyc  = 0;
    int pulse_cyc = 0;
    int pulse_cnt [N];

    initial for (int i = 0; i < N; i++) pulse_cnt[i] = 0;

    always @(negedge clk100) begin
        if (c7m_falling) fall_cyc++;
        if (|z3_pulse) pulse_cyc++;
        for (int i = 0; i < N; i++) if (z3_pulse[i]) pulse_cnt[i]++;
    end

    // Model: number of consecutive low samples per slot, plus Z3 registration.
    int           lowrun [N];
    logic [N-1:0] m_z3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s txn=%0d observed=%0h expected=%0h", tag, txn, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) lowrun[i] = 0;
        m_z3 = '0;
    endtask

    task automatic model_sample(input logic [N-1:0] ebr);
        exp_t e;
        e.pulse = '0;
        e.z2    = '0;
        e.fault = '0;
        for (int i = 0; i < N; i++) begin
            if (ebr[i]) begin
                if (lowrun[i] == 1) e.pulse[i] = 1'b1;
                lowrun[i] = 0;
            end else if (lowrun[i] < 1000) begin
                lowrun[i]++;
            end
            e.fault[i] = TO_EN && (lowrun[i] >= TO + 2);
            e.z2[i]    = (lowrun[i] >= 2) && !e.fault[i];
        end
        m_z3 = m_z3 ^ e.pulse;
        e.z3 = m_z3;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk100);
        reset_n_in = 1'b0;
        c7m_in     = 1'b1;
        repeat (3) @(negedge clk100);
        reset_n_in = 1'b1;
        model_reset();
        e.z3 = '0; e.z2 = '0; e.fault = '0; e.pulse = '0;
        exp_q.push_back(e);
        @(negedge clk100);
        e = exp_q.pop_front();
        chk("rst_z3", 32'(z3_requests), 32'(e.z3));
        chk("rst_z2", 32'(z2_requests), 32'(e.z2));
        chk("rst_fault", 32'(slot_fault), 32'(e.fault));
        chk("rst_pulse", 32'(z3_pulse), 32'(e.pulse));
        chk("rst_falling", 32'(c7m_falling), 32'd0);
        $display("txn %0d reset z3=%b z2=%b fault=%b", txn, z3_requests, z2_requests, slot_fault);
        txn++;
    endtask

    // One C7M period: optional 2-cycle glitch, 4 stable cycles, then the fall.
    task automatic run_period(input logic [N-1:0] ebr, input logic [N-1:0] glitch);
        exp_t         e;
        int           p0 [N];
        int           pc0;
        int           f0;
        logic [N-1:0] seen;
        for (int i = 0; i < N; i++) p0[i] = pulse_cnt[i];
        pc0 = pulse_cyc;
        f0  = fall_cyc;
        @(negedge clk100);
        c7m_in   = 1'b1;
        ebr_n_in = ebr & ~glitch;
        model_sample(ebr);
        repeat (2) @(negedge clk100);
        ebr_n_in = ebr;
        repeat (4) @(negedge clk100);
        c7m_in = 1'b0;
        repeat (5) @(negedge clk100);
        e = exp_q.pop_front();
        for (int i = 0; i < N; i++) seen[i] = (pulse_cnt[i] != p0[i]);
        chk("z3", 32'(z3_requests), 32'(e.z3));
        chk("z2", 32'(z2_requests), 32'(e.z2));
        chk("fault", 32'(slot_fault), 32'(e.fault));
        chk("pulse_slots", 32'(seen), 32'(e.pulse));
        chk("pulse_cycles", 32'(pulse_cyc - pc0), (e.pulse != '0) ? 32'd1 : 32'd0);
        chk("falling_strobes", 32'(fall_cyc - f0), 32'd1);
        $display("txn %0d ebr=%b z3=%b z2=%b pulse=%b fault=%b",
                 txn, ebr, z3_requests, z2_requests, seen, slot_fault);
        txn++;
    endtask

    initial begin
        reset_n_in = 1'b0;
        c7m_in     = 1'b1;
        ebr_n_in   = '1;
        model_reset();
        do_reset();

        run_period(5'b11111, 5'b00000);
        // Slot 2 single pulse registers, second pulse deregisters, third re-registers.
        for (int r = 0; r < 3; r++) begin
            run_period(5'b11011, 5'b00000);
            run_period(5'b11111, 5'b00000);
        end
        // Slot 0 held low: Z2 from the 2nd sample, released after one high sample.
        repeat (5) run_period(5'b11110, 5'b00000);
        run_period(5'b11111, 5'b00000);
        // Slots 1 and 4 pulse together.
        run_period(5'b01101, 5'b00000);
        run_period(5'b11111, 5'b00000);
        // Short low glitches between falls must not be sampled.
        run_period(5'b11111, 5'b11111);
        run_period(5'b11111, 5'b01010);
        // Reset while slot 3 sits in S_LOW1 with EBR still low.
        run_period(5'b10111, 5'b00000);
        do_reset();
        run_period(5'b11111, 5'b00000);
        run_period(5'b10111, 5'b00000);
        run_period(5'b11111, 5'b00000);
        // Slot 3 registered for Z3 while also raising a Z2 request.
        repeat (3) run_period(5'b10111, 5'b00000);
        run_period(5'b11111, 5'b00000);
        // Reset released with a slot already low: two samples needed for Z2.
        run_period(5'b11101, 5'b00000);
        run_period(5'b11101, 5'b00000);
        do_reset();
        run_period(5'b11101, 5'b00000);
        run_period(5'b11101, 5'b00000);
        run_period(5'b11111, 5'b00000);
        if (TO_EN) begin
            repeat (12) run_period(5'b11101, 5'b00000);
            run_period(5'b11111, 5'b00000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ebr_request_decoder.md
# ebr_request_decoder

Front end of Zorro bus-request handling: samples the five expansion-slot EBR_n lines on C7M falling edges and classifies each slot's activity. A single-period low pulse toggles that slot's Zorro III registration; a low held for two or more edges is a Zorro II request. Outputs are the registered `z3_requests` and `z2_requests` vectors and a C7M falling-edge strobe, all consumed directly by the bus-arbitration stage in `rebuster_core`.

## Interface
Parameters:
- NUM_SLOTS, 5, number of EBR/EBG slot pairs.
- TIMEOUT_CYCLES, 4096, C7M periods a Z2 request may stay held before the slot is faulted (only with EBR_TIMEOUT_EN).

Ports:
- clk100  in  1  system clock, 100 MHz; all state changes on its rising edge.
- reset_n_in  in  1  reset, synchronous active-low; sampled on clk100, already synchronized upstream.
- c7m_in  in  1  raw C7M; synchronized internally.
- ebr_n_in  in  NUM_SLOTS  raw slot EBR_n; synchronized internally.
- c7m_falling  out  1  one-clk100 strobe, C7M falling edge detected.
- z3_requests  out  NUM_SLOTS  per-slot Z3 registration, level.
- z2_requests  out  NUM_SLOTS  per-slot Z2 request, level.
- z3_pulse  out  NUM_SLOTS  one-clk100 strobe per slot on a toggle event (debug/trace).
- slot_fault  out  NUM_SLOTS  slot masked by timeout (tied 0 without EBR_TIMEOUT_EN).

## Operation
- C7M: 3-flop shift register; `c7m_falling` = sync[2:1]==2'b10, registered.
- EBR: 2-flop sync per slot. The synced value is sampled only when the internal falling strobe is high.
- Per-slot FSM, advancing only on a falling strobe:
  - S_HIGH: sample low -> S_LOW1; otherwise stay.
  - S_LOW1: sample high -> S_HIGH, toggle `z3_requests[i]`, pulse `z3_pulse[i]`. Sample low -> S_LOWN.
  - S_LOWN: `z2_requests[i]`=1. Sample high -> S_HIGH with `z2_requests[i]`=0. Sample low -> stay.
- Pulse rule: exactly one low sample between high samples toggles the slot. Two or more consecutive low samples never toggle.
- A slot may hold Z3 registration and assert Z2 simultaneously. Both bits are reported and the arbiter resolves priority.
- Slots are independent. Simultaneous toggles on several slots in the same strobe are all applied.
- Reset, including mid-pulse or mid-request, forces every FSM to S_HIGH and clears all outputs. A slot low at reset release passes through S_LOW1 first and needs two low samples to reach Z2.

## Timing
- Reset values: c7m_falling=0, z3_requests=0, z2_requests=0, z3_pulse=0, slot_fault=0. Sync flops reset to 1 (EBR) and 0 (C7M).
- Latency: C7M pin falling edge to `c7m_falling` is 3-4 clk100 cycles. Request outputs update on the clk100 cycle after the strobe, i.e. one cycle after `c7m_falling`.
- EBR must be stable for ≥3 clk100 cycles before the C7M falling edge to be captured in that period.
- Z2 assertion takes two falling edges after EBR goes low. Z2 negation takes one falling edge after EBR goes high.
- `z3_pulse` is high for exactly one clk100 cycle, coincident with the `z3_requests` change.

## Configuration
- EBR_TIMEOUT_EN defined:
  - Each slot has a C7M-edge counter in S_LOWN that saturates at TIMEOUT_CYCLES.
  - When the counter reaches TIMEOUT_CYCLES, `slot_fault[i]`=1 and `z2_requests[i]` is forced to 0.
  - The fault clears when the FSM leaves S_LOWN.
  - The counter is cleared on entry to S_LOWN.
- EBR_TIMEOUT_EN undefined:
  - No counters; `slot_fault` is constant 0.
  - A Z2 request is held indefinitely.

## Structure
- Shared package `rebuster_pkg` holds:
  - the slot-FSM state encoding (S_HIGH=2'd0, S_LOW1=2'd1, S_LOWN=2'd2);
  - NUM_SLOTS_DEFAULT=5;
  - the timeout counter width, computed from TIMEOUT_CYCLES.
- Sub-module `ebr_slot_fsm`, one instance per slot, generated. Ports: clk100, reset_n_in, sample strobe, synced EBR bit; outputs: toggle, z2, fault.
- C7M/EBR synchronizers and the `z3_requests` register live in the top.

## Test plan
- Reset, then EBR slot 2 high/low/high across three C7M falling edges -> `z3_requests`=5'b00100 and one `z3_pulse[2]`. Repeat the pattern -> `z3_requests`=5'b00000.
- Slot 0 held low for 5 falling edges -> `z2_requests[0]`=1 from the 2nd edge. EBR high -> cleared after the next edge; `z3_requests` unchanged.
- Slots 1 and 4 pulse on the same C7M period -> both bits toggle in the same cycle, and `z3_pulse`=5'b10010 for one cycle.
- Reset asserted while slot 3 is in S_LOW1 -> after release no toggle occurs. A single low sample straight after release toggles only if a high sample follows.
- EBR_TIMEOUT_EN, TIMEOUT_CYCLES=8, slot 1 held low 12 edges -> `z2_requests[1]` drops and `slot_fault[1]`=1 at count 8. EBR high -> fault clears.
- EBR glitch low lasting 2 clk100 cycles between C7M edges -> no state change on any output.
